// File: rtl/macguffin_pkg.sv
// rtl/macguffin_pkg.sv - shared width, word type and bit-permutation table for the MacGuffin P-box
package macguffin_pkg;

    localparam int PBOX_W = 48;

    typedef logic [PBOX_W-1:0] pbox_word_t;

    // Source bit of data for each output bit; element i feeds out[i].
    // Six-entry rows, starting at out[0], are the S-box input groups from the LSB end.
    localparam logic [5:0] PBOX_SRC [PBOX_W] = '{
        6'd6,  6'd12, 6'd27, 6'd31, 6'd34, 6'd36,
        6'd8,  6'd13, 6'd20, 6'd26, 6'd32, 6'd38,
        6'd10, 6'd14, 6'd16, 6'd19, 6'd39, 6'd40,
        6'd3,  6'd9,  6'd17, 6'd28, 6'd37, 6'd47,
        6'd5,  6'd11, 6'd29, 6'd30, 6'd33, 6'd35,
        6'd0,  6'd15, 6'd18, 6'd23, 6'd41, 6'd44,
        6'd1,  6'd7,  6'd21, 6'd24, 6'd43, 6'd46,
        6'd2,  6'd4,  6'd22, 6'd25, 6'd42, 6'd45
    };

endpackage

// File: rtl/macguffin_p_box_comb.sv
// rtl/macguffin_p_box_comb.sv - pure wiring map data -> P(data) built from PBOX_SRC
module macguffin_p_box_comb
    import macguffin_pkg::*;
(
    input  logic [PBOX_W-1:0] data,
    output logic [PBOX_W-1:0] perm
);

    for (genvar i = 0; i < PBOX_W; i++) begin : g_bit
        assign perm[i] = data[PBOX_SRC[i]];
    end

endmodule

// File: rtl/macguffin_p_box.sv
// rtl/macguffin_p_box.sv - 48-bit P-box with combinational output and a valid-qualified registered copy
module macguffin_p_box
    import macguffin_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PBOX_W-1:0] data,
    input  logic              in_valid,
    output logic [PBOX_W-1:0] permutation,
    output logic [PBOX_W-1:0] perm_q,
    output logic              out_valid
);

    pbox_word_t perm_comb;
    pbox_word_t perm_d;
    logic       out_valid_d;
    logic       out_valid_q;

    macguffin_p_box_comb u_comb (
        .data (data),
        .perm (perm_comb)
    );

    assign permutation = perm_comb;
    assign out_valid   = out_valid_q;

    // The register holds its last result across gaps; only the flag drops.
    always_comb begin
        perm_d      = perm_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            perm_d      = perm_comb;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perm_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            perm_q      <= perm_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_macguffin_p_box.sv
// tb/tb_macguffin_p_box.sv - self-checking bench for macguffin_p_box against a grouped-table model
module tb_macguffin_p_box;

    logic        clk;
    logic        rst;
    logic [47:0] data;
    logic        in_valid;
    logic [47:0] permutation;
    logic [47:0] perm_q;
    logic        out_valid;

    int tests;
    int fails;

    // Source indices per S-box group, groups MSB-first, bits high to low within a group.
    int grp [8][6] = '{
        '{45, 42, 25, 22, 4,  2},
        '{46, 43, 24, 21, 7,  1},
        '{44, 41, 23, 18, 15, 0},
        '{35, 33, 30, 29, 11, 5},
        '{47, 37, 28, 17, 9,  3},
        '{40, 39, 19, 16, 14, 10},
        '{38, 32, 26, 20, 13, 8},
        '{36, 34, 31, 27, 12, 6}
    };

    macguffin_p_box dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .in_valid    (in_valid),
        .permutation (permutation),
        .perm_q      (perm_q),
        .out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] p_ref(input logic [47:0] d);
        logic [47:0] r;
        r = '0;
        for (int g = 0; g < 8; g++)
            for (int j = 0; j < 6; j++)
                r[47 - (g * 6 + j)] = d[grp[g][j]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [47:0] w, a, b, c, exp_q;
    logic        exp_v;

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        data     = '0;
        #1;
        tick();
        tick();
        check("reset_perm_q", perm_q, 48'h0);
        check("reset_out_valid", {47'b0, out_valid}, 48'h0);
        data = {$urandom, $urandom};
        #1;
        check("comb_during_reset", permutation, p_ref(data));

        rst = 1'b0;
        data = 48'h1 << 45; #1; check("ex_45_to_47", permutation, 48'h1 << 47);
        data = 48'h1 << 6;  #1; check("ex_6_to_0",   permutation, 48'h1);
        data = 48'h1 << 47; #1; check("ex_47_to_23", permutation, 48'h1 << 23);
        data = 48'h1;       #1; check("ex_0_to_30",  permutation, 48'h1 << 30);

        for (int k = 0; k < 48; k++) begin
            data = 48'h1 << k;
            #1;
            check($sformatf("walk1_%0d", k), permutation, p_ref(data));
        end
        for (int k = 0; k < 48; k++) begin
            data = ~(48'h1 << k);
            #1;
            check($sformatf("walk0_%0d", k), permutation, ~p_ref(48'h1 << k));
        end

        data = 48'h0;              #1; check("all_zero", permutation, 48'h0);
        data = 48'hFFFF_FFFF_FFFF; #1; check("all_ones", permutation, 48'hFFFF_FFFF_FFFF);

        for (int n = 0; n < 100; n++) begin
            data = {$urandom, $urandom};
            #1;
            check("rand_model", permutation, p_ref(data));
            check("rand_popcount", 48'($countones(permutation)), 48'($countones(data)));
        end

        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        c = {$urandom, $urandom};
        in_valid = 1'b1;
        data = a; tick();
        check("burst_a", perm_q, p_ref(a));
        check("burst_a_v", {47'b0, out_valid}, 48'h1);
        data = b; tick();
        check("burst_b", perm_q, p_ref(b));
        check("burst_b_v", {47'b0, out_valid}, 48'h1);
        data = c; tick();
        check("burst_c", perm_q, p_ref(c));
        check("burst_c_v", {47'b0, out_valid}, 48'h1);
        in_valid = 1'b0;
        data = {$urandom, $urandom};
        tick();
        check("gap_hold", perm_q, p_ref(c));
        check("gap_v", {47'b0, out_valid}, 48'h0);

        rst = 1'b1;
        in_valid = 1'b1;
        data = {$urandom, $urandom};
        #1;
        check("rst_comb", permutation, p_ref(data));
        tick();
        check("rst_drop_q", perm_q, 48'h0);
        check("rst_drop_v", {47'b0, out_valid}, 48'h0);
        rst = 1'b0;
        w = {$urandom, $urandom};
        data = w;
        tick();
        check("post_rst_q", perm_q, p_ref(w));
        check("post_rst_v", {47'b0, out_valid}, 48'h1);

        exp_q = p_ref(w);
        for (int n = 0; n < 60; n++) begin
            data     = {$urandom, $urandom};
            in_valid = 1'($urandom_range(0, 1));
            rst      = ($urandom_range(0, 15) == 0);
            if (rst) begin
                exp_q = '0;
                exp_v = 1'b0;
            end else if (in_valid) begin
                exp_q = p_ref(data);
                exp_v = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
            tick();
            check("stream_q", perm_q, exp_q);
            check("stream_v", {47'b0, out_valid}, {47'b0, exp_v});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
